// File: rtl/tx_write_responder.sv
// Write responder: accepts one command, emits its generated payload, then one status word.
// Payload lanes carry incrementing 48-bit local addresses; the status word echoes the command.
module tx_write_responder #(
  parameter int C_S_AXIS_TX_META_TDATA_WIDTH   = 256,
  parameter int C_M_AXIS_TX_DATA_TDATA_WIDTH   = 512,
  parameter int C_M_AXIS_TX_STATUS_TDATA_WIDTH = 512
) (
  input  logic                                        ap_clk,
  input  logic                                        areset,

  input  logic                                        s_axis_tx_meta_tvalid,
  output logic                                        s_axis_tx_meta_tready,
  input  logic [C_S_AXIS_TX_META_TDATA_WIDTH-1:0]     s_axis_tx_meta_tdata,
  input  logic [C_S_AXIS_TX_META_TDATA_WIDTH/8-1:0]   s_axis_tx_meta_tkeep,
  input  logic                                        s_axis_tx_meta_tlast,

  output logic                                        m_axis_tx_data_tvalid,
  input  logic                                        m_axis_tx_data_tready,
  output logic [C_M_AXIS_TX_DATA_TDATA_WIDTH-1:0]     m_axis_tx_data_tdata,
  output logic [C_M_AXIS_TX_DATA_TDATA_WIDTH/8-1:0]   m_axis_tx_data_tkeep,
  output logic                                        m_axis_tx_data_tlast,

  output logic                                        m_axis_tx_status_tvalid,
  input  logic                                        m_axis_tx_status_tready,
  output logic [C_M_AXIS_TX_STATUS_TDATA_WIDTH-1:0]   m_axis_tx_status_tdata,
  output logic [C_M_AXIS_TX_STATUS_TDATA_WIDTH/8-1:0] m_axis_tx_status_tkeep,
  output logic                                        m_axis_tx_status_tlast,

  output logic [31:0]                                 cmd_count,
  output logic [31:0]                                 err_count
);

  // state    | meaning
  // S_IDLE   | meta_tready high, waiting for a command
  // S_DATA   | streaming payload beats, beats_left_q counts down to the last one
  // S_STATUS | holding the completion word until it handshakes

  localparam int MW = C_S_AXIS_TX_META_TDATA_WIDTH;
  localparam int DW = C_M_AXIS_TX_DATA_TDATA_WIDTH;
  localparam int KW = DW / 8;
  localparam int SW = C_M_AXIS_TX_STATUS_TDATA_WIDTH;
  localparam logic [2:0] OP_WRITE = 3'b001;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_STATUS} state_t;

  state_t         state_q, state_d;
  logic           meta_rdy_q, meta_rdy_d;
  logic [2:0]     op_q, op_d;
  logic [23:0]    qpn_q, qpn_d;
  logic [47:0]    addr_q, addr_d;
  logic [47:0]    raddr_q, raddr_d;
  logic [31:0]    len_q, len_d;
  logic [26:0]    beats_left_q, beats_left_d;
  logic           d_valid_q, d_valid_d;
  logic [DW-1:0]  d_data_q, d_data_d;
  logic [KW-1:0]  d_keep_q, d_keep_d;
  logic           d_last_q, d_last_d;
  logic           s_valid_q, s_valid_d;
  logic [SW-1:0]  s_data_q, s_data_d;
  logic [31:0]    cmd_cnt_q, cmd_cnt_d;
  logic [31:0]    err_cnt_q, err_cnt_d;

  logic           meta_hs, data_hs, stat_hs;
  logic [2:0]     m_op;
  logic [23:0]    m_qpn;
  logic [47:0]    m_laddr, m_raddr;
  logic [31:0]    m_len;
  logic [26:0]    m_beats;
  logic [47:0]    next_addr;

  logic unused_meta;
  assign unused_meta = ^{s_axis_tx_meta_tkeep, s_axis_tx_meta_tlast, s_axis_tx_meta_tdata[MW-1:155]};

  function automatic logic [DW-1:0] beat_data(input logic [47:0] base);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < DW / 64; i++) begin
      v[i*64 +: 64] = {16'h0000, base + 48'(8 * i)};
    end
    return v;
  endfunction

  // Partial final beat keeps only the low (len mod 64) byte lanes.
  function automatic logic [KW-1:0] last_keep(input logic [5:0] rem);
    logic [KW-1:0] k;
    k = '1;
    if (rem != 6'd0) begin
      for (int i = 0; i < KW; i++) k[i] = (i < int'(rem));
    end
    return k;
  endfunction

  function automatic logic [SW-1:0] status_word(input logic [2:0] op, input logic [23:0] qpn,
                                                input logic [31:0] len, input logic [47:0] raddr);
    logic [SW-1:0] w;
    w          = '0;
    w[23:0]    = qpn;
    w[55:24]   = len;
    w[58:56]   = op;
    w[59]      = (op != OP_WRITE);
    w[107:60]  = raddr;
    return w;
  endfunction

  assign m_op      = s_axis_tx_meta_tdata[2:0];
  assign m_qpn     = s_axis_tx_meta_tdata[26:3];
  assign m_laddr   = s_axis_tx_meta_tdata[74:27];
  assign m_raddr   = s_axis_tx_meta_tdata[122:75];
  assign m_len     = s_axis_tx_meta_tdata[154:123];
  assign m_beats   = {1'b0, m_len[31:6]} + {26'd0, |m_len[5:0]};
  assign next_addr = addr_q + 48'd64;

  assign meta_hs = s_axis_tx_meta_tvalid & meta_rdy_q;
  assign data_hs = d_valid_q & m_axis_tx_data_tready;
  assign stat_hs = s_valid_q & m_axis_tx_status_tready;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    qpn_d        = qpn_q;
    addr_d       = addr_q;
    raddr_d      = raddr_q;
    len_d        = len_q;
    beats_left_d = beats_left_q;
    d_valid_d    = d_valid_q;
    d_data_d     = d_data_q;
    d_keep_d     = d_keep_q;
    d_last_d     = d_last_q;
    s_valid_d    = s_valid_q;
    s_data_d     = s_data_q;
    cmd_cnt_d    = cmd_cnt_q;
    err_cnt_d    = err_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (meta_hs) begin
          op_d    = m_op;
          qpn_d   = m_qpn;
          addr_d  = m_laddr;
          raddr_d = m_raddr;
          len_d   = m_len;
          if (m_op == OP_WRITE && m_len != 32'd0) begin
            state_d      = S_DATA;
            beats_left_d = m_beats;
            d_valid_d    = 1'b1;
            d_data_d     = beat_data(m_laddr);
            d_last_d     = (m_beats == 27'd1);
            d_keep_d     = (m_beats == 27'd1) ? last_keep(m_len[5:0]) : '1;
          end else begin
            state_d   = S_STATUS;
            s_valid_d = 1'b1;
            s_data_d  = status_word(m_op, m_qpn, m_len, m_raddr);
          end
        end
      end
      S_DATA: begin
        if (data_hs) begin
          if (beats_left_q == 27'd1) begin
            state_d   = S_STATUS;
            d_valid_d = 1'b0;
            d_data_d  = '0;
            d_keep_d  = '0;
            d_last_d  = 1'b0;
            s_valid_d = 1'b1;
            s_data_d  = status_word(op_q, qpn_q, len_q, raddr_q);
          end else begin
            beats_left_d = beats_left_q - 27'd1;
            addr_d       = next_addr;
            d_data_d     = beat_data(next_addr);
            d_last_d     = (beats_left_q == 27'd2);
            d_keep_d     = (beats_left_q == 27'd2) ? last_keep(len_q[5:0]) : '1;
          end
        end
      end
      S_STATUS: begin
        if (stat_hs) begin
          state_d   = S_IDLE;
          s_valid_d = 1'b0;
          s_data_d  = '0;
          cmd_cnt_d = cmd_cnt_q + 32'd1;
          err_cnt_d = err_cnt_q + {31'd0, op_q != OP_WRITE};
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered ready: low through reset, high one edge after release.
    meta_rdy_d = (state_d == S_IDLE);
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      state_q      <= S_IDLE;
      meta_rdy_q   <= 1'b0;
      op_q         <= '0;
      qpn_q        <= '0;
      addr_q       <= '0;
      raddr_q      <= '0;
      len_q        <= '0;
      beats_left_q <= '0;
      d_valid_q    <= 1'b0;
      d_data_q     <= '0;
      d_keep_q     <= '0;
      d_last_q     <= 1'b0;
      s_valid_q    <= 1'b0;
      s_data_q     <= '0;
      cmd_cnt_q    <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      meta_rdy_q   <= meta_rdy_d;
      op_q         <= op_d;
      qpn_q        <= qpn_d;
      addr_q       <= addr_d;
      raddr_q      <= raddr_d;
      len_q        <= len_d;
      beats_left_q <= beats_left_d;
      d_valid_q    <= d_valid_d;
      d_data_q     <= d_data_d;
      d_keep_q     <= d_keep_d;
      d_last_q     <= d_last_d;
      s_valid_q    <= s_valid_d;
      s_data_q     <= s_data_d;
      cmd_cnt_q    <= cmd_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign s_axis_tx_meta_tready   = meta_rdy_q;
  assign m_axis_tx_data_tvalid   = d_valid_q;
  assign m_axis_tx_data_tdata    = d_data_q;
  assign m_axis_tx_data_tkeep    = d_keep_q;
  assign m_axis_tx_data_tlast    = d_last_q;
  assign m_axis_tx_status_tvalid = s_valid_q;
  assign m_axis_tx_status_tdata  = s_data_q;
  assign m_axis_tx_status_tkeep  = {(SW/8){s_valid_q}};
  assign m_axis_tx_status_tlast  = s_valid_q;
  assign cmd_count               = cmd_cnt_q;
  assign err_count               = err_cnt_q;

endmodule

// File: tb/tb_tx_write_responder.sv
// Bench for tx_write_responder: directed and random commands checked against an
// address-arithmetic model of payload, keep, status word and counters.
module tb_tx_write_responder;

  logic           ap_clk = 1'b0;
  logic           areset;
  logic           s_axis_tx_meta_tvalid;
  logic           s_axis_tx_meta_tready;
  logic [255:0]   s_axis_tx_meta_tdata;
  logic [31:0]    s_axis_tx_meta_tkeep;
  logic           s_axis_tx_meta_tlast;
  logic           m_axis_tx_data_tvalid;
  logic           m_axis_tx_data_tready;
  logic [511:0]   m_axis_tx_data_tdata;
  logic [63:0]    m_axis_tx_data_tkeep;
  logic           m_axis_tx_data_tlast;
  logic           m_axis_tx_status_tvalid;
  logic           m_axis_tx_status_tready;
  logic [511:0]   m_axis_tx_status_tdata;
  logic [63:0]    m_axis_tx_status_tkeep;
  logic           m_axis_tx_status_tlast;
  logic [31:0]    cmd_count;
  logic [31:0]    err_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_cmd = 0;
  logic [31:0] exp_err = 0;

  always #5 ap_clk = ~ap_clk;

  tx_write_responder dut (
    .ap_clk                  (ap_clk),
    .areset                  (areset),
    .s_axis_tx_meta_tvalid   (s_axis_tx_meta_tvalid),
    .s_axis_tx_meta_tready   (s_axis_tx_meta_tready),
    .s_axis_tx_meta_tdata    (s_axis_tx_meta_tdata),
    .s_axis_tx_meta_tkeep    (s_axis_tx_meta_tkeep),
    .s_axis_tx_meta_tlast    (s_axis_tx_meta_tlast),
    .m_axis_tx_data_tvalid   (m_axis_tx_data_tvalid),
    .m_axis_tx_data_tready   (m_axis_tx_data_tready),
    .m_axis_tx_data_tdata    (m_axis_tx_data_tdata),
    .m_axis_tx_data_tkeep    (m_axis_tx_data_tkeep),
    .m_axis_tx_data_tlast    (m_axis_tx_data_tlast),
    .m_axis_tx_status_tvalid (m_axis_tx_status_tvalid),
    .m_axis_tx_status_tready (m_axis_tx_status_tready),
    .m_axis_tx_status_tdata  (m_axis_tx_status_tdata),
    .m_axis_tx_status_tkeep  (m_axis_tx_status_tkeep),
    .m_axis_tx_status_tlast  (m_axis_tx_status_tlast),
    .cmd_count               (cmd_count),
    .err_count               (err_count)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] model_beat(input logic [47:0] laddr, input longint unsigned k);
    logic [511:0] v;
    logic [63:0] a;
    for (int i = 0; i < 8; i++) begin
      a = (64'(laddr) + 64'(k) * 64'd64 + 64'(i) * 64'd8) % 64'h0001_0000_0000_0000;
      v[i*64 +: 64] = a;
    end
    return v;
  endfunction

  function automatic logic [63:0] model_keep(input logic [31:0] len);
    int rem;
    logic [63:0] k;
    rem = int'(len % 32'd64);
    k = '1;
    if (rem != 0) k = (64'd1 << rem) - 64'd1;
    return k;
  endfunction

  function automatic logic [255:0] pack_meta(input logic [2:0] op, input logic [23:0] qpn,
                                             input logic [47:0] laddr, input logic [47:0] raddr,
                                             input logic [31:0] len);
    logic [255:0] m;
    m = '0;
    m[2:0]     = op;
    m[26:3]    = qpn;
    m[74:27]   = laddr;
    m[122:75]  = raddr;
    m[154:123] = len;
    m[186:155] = $urandom;
    return m;
  endfunction

  function automatic logic [511:0] model_status(input logic [2:0] op, input logic [23:0] qpn,
                                                input logic [47:0] raddr, input logic [31:0] len);
    logic [511:0] s;
    s = '0;
    s[23:0]   = qpn;
    s[55:24]  = len;
    s[58:56]  = op;
    s[59]     = (op != 3'd1);
    s[107:60] = raddr;
    return s;
  endfunction

  // Called at a negedge; returns at a negedge after the status handshake.
  task automatic run_cmd(input logic [2:0] op, input logic [23:0] qpn, input logic [47:0] laddr,
                         input logic [47:0] raddr, input logic [31:0] len,
                         input bit rand_ready, input int stat_stall);
    longint unsigned nbeats, k;
    int budget;
    logic [511:0] est;
    budget = 0;
    while (!s_axis_tx_meta_tready && budget < 50) begin
      @(negedge ap_clk);
      budget++;
    end
    check("meta_tready_idle", s_axis_tx_meta_tready, 1);
    s_axis_tx_meta_tvalid = 1'b1;
    s_axis_tx_meta_tdata  = pack_meta(op, qpn, laddr, raddr, len);
    s_axis_tx_meta_tkeep  = $urandom;
    s_axis_tx_meta_tlast  = 1'($urandom_range(0, 1));
    @(posedge ap_clk);
    @(negedge ap_clk);
    s_axis_tx_meta_tvalid = 1'b0;
    s_axis_tx_meta_tdata  = {8{$urandom}};
    check("meta_tready_busy", s_axis_tx_meta_tready, 0);

    nbeats = (op == 3'd1) ? (longint'(len) + 63) / 64 : 0;
    k = 0;
    budget = 0;
    while (k < nbeats && budget < 5000) begin
      check("data_tvalid", m_axis_tx_data_tvalid, 1);
      check("data_tdata", m_axis_tx_data_tdata, model_beat(laddr, k));
      check("data_tkeep", m_axis_tx_data_tkeep, (k == nbeats - 1) ? model_keep(len) : 64'hFFFF_FFFF_FFFF_FFFF);
      check("data_tlast", m_axis_tx_data_tlast, (k == nbeats - 1) ? 1 : 0);
      check("meta_tready_data", s_axis_tx_meta_tready, 0);
      m_axis_tx_data_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge ap_clk);
      if (m_axis_tx_data_tready) k++;
      @(negedge ap_clk);
      budget++;
    end
    m_axis_tx_data_tready = 1'b0;
    check("data_beat_total", 512'(k), 512'(nbeats));

    est = model_status(op, qpn, raddr, len);
    for (int j = 0; j < stat_stall; j++) begin
      check("status_tvalid_stall", m_axis_tx_status_tvalid, 1);
      check("status_tdata_stall", m_axis_tx_status_tdata, est);
      check("meta_tready_stall", s_axis_tx_meta_tready, 0);
      check("data_tvalid_status", m_axis_tx_data_tvalid, 0);
      @(posedge ap_clk);
      @(negedge ap_clk);
    end
    m_axis_tx_status_tready = 1'b1;
    check("status_tvalid", m_axis_tx_status_tvalid, 1);
    check("status_tdata", m_axis_tx_status_tdata, est);
    check("status_tkeep", m_axis_tx_status_tkeep, 64'hFFFF_FFFF_FFFF_FFFF);
    check("status_tlast", m_axis_tx_status_tlast, 1);
    check("data_tvalid_idle", m_axis_tx_data_tvalid, 0);
    @(posedge ap_clk);
    exp_cmd = exp_cmd + 1;
    if (op != 3'd1) exp_err = exp_err + 1;
    @(negedge ap_clk);
    m_axis_tx_status_tready = 1'b0;
    check("status_tvalid_done", m_axis_tx_status_tvalid, 0);
    check("cmd_count", cmd_count, exp_cmd);
    check("err_count", err_count, exp_err);
    check("meta_tready_back", s_axis_tx_meta_tready, 1);
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_len;
    logic [47:0] big_laddr;
    areset = 1'b1;
    s_axis_tx_meta_tvalid   = 1'b0;
    s_axis_tx_meta_tdata    = '0;
    s_axis_tx_meta_tkeep    = '0;
    s_axis_tx_meta_tlast    = 1'b0;
    m_axis_tx_data_tready   = 1'b0;
    m_axis_tx_status_tready = 1'b0;

    repeat (2) @(negedge ap_clk);
    check("rst_meta_tready", s_axis_tx_meta_tready, 0);
    check("rst_data_tvalid", m_axis_tx_data_tvalid, 0);
    check("rst_data_tdata", m_axis_tx_data_tdata, 0);
    check("rst_status_tvalid", m_axis_tx_status_tvalid, 0);
    check("rst_status_tkeep", m_axis_tx_status_tkeep, 0);
    check("rst_cmd_count", cmd_count, 0);
    areset = 1'b0;
    check("rel_meta_tready_pre", s_axis_tx_meta_tready, 0);
    @(posedge ap_clk);
    @(negedge ap_clk);
    check("rel_meta_tready_post", s_axis_tx_meta_tready, 1);

    run_cmd(3'd1, 24'h00ABCD, 48'h0000_0000_1000, 48'h0000_DEAD_BEEF, 32'd128, 1'b0, 0);
    run_cmd(3'd1, 24'h000011, 48'h0000_0000_2000, 48'h0000_0000_0044, 32'd100, 1'b0, 0);
    run_cmd(3'd2, 24'h123456, 48'h0000_0000_3000, 48'h0000_0000_5000, 32'd256, 1'b0, 1);
    run_cmd(3'd1, 24'h000001, 48'h0000_0000_4000, 48'h0000_0000_6000, 32'd0, 1'b0, 0);
    run_cmd(3'd1, 24'h00BEEF, 48'h0000_0001_0040, 48'h0000_1234_5678, 32'd320, 1'b1, 10);
    big_laddr = 48'hFFFF_FFFF_FFE0;
    run_cmd(3'd1, 24'hFFFFFF, big_laddr, 48'hFFFF_FFFF_FFFF, 32'd200, 1'b1, 2);
    run_cmd(3'd1, 24'h000002, 48'h0000_0000_0008, 48'h0, 32'd1, 1'b0, 0);

    // Reset in the middle of a len=640 command, during its third beat.
    s_axis_tx_meta_tvalid = 1'b1;
    s_axis_tx_meta_tdata  = pack_meta(3'd1, 24'h000777, 48'h0000_0000_8000, 48'h0000_0000_9000, 32'd640);
    @(posedge ap_clk);
    @(negedge ap_clk);
    s_axis_tx_meta_tvalid = 1'b0;
    m_axis_tx_data_tready = 1'b1;
    repeat (2) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
    end
    check("mid_data_beat2", m_axis_tx_data_tdata, model_beat(48'h0000_0000_8000, 2));
    areset = 1'b1;
    #1;
    check("arst_data_tvalid", m_axis_tx_data_tvalid, 0);
    check("arst_data_tdata", m_axis_tx_data_tdata, 0);
    check("arst_data_tkeep", m_axis_tx_data_tkeep, 0);
    check("arst_data_tlast", m_axis_tx_data_tlast, 0);
    check("arst_status_tvalid", m_axis_tx_status_tvalid, 0);
    check("arst_meta_tready", s_axis_tx_meta_tready, 0);
    check("arst_cmd_count", cmd_count, 0);
    check("arst_err_count", err_count, 0);
    m_axis_tx_data_tready = 1'b0;
    exp_cmd = 0;
    exp_err = 0;
    @(negedge ap_clk);
    areset = 1'b0;
    @(posedge ap_clk);
    @(negedge ap_clk);
    check("arst_rel_meta_tready", s_axis_tx_meta_tready, 1);
    check("arst_rel_status_tvalid", m_axis_tx_status_tvalid, 0);
    run_cmd(3'd1, 24'h000888, 48'h0000_0000_A000, 48'h0000_0000_B000, 32'd640, 1'b0, 0);

    for (int n = 0; n < 10; n++) begin
      r_op  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
      r_len = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 64)) : 32'($urandom_range(0, 700));
      run_cmd(r_op, 24'($urandom), {16'($urandom), $urandom}, {16'($urandom), $urandom},
              r_len, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
